// File: rtl/sr_scan.sv
// sr_scan: scanner for a daisy-chained 74HC165-style parallel-in/serial-out
// chain. It loads the chain, shifts the word in through a synchronizer, and
// debounces the captured word across consecutive scans before publishing it.
module sr_scan #(
    parameter int WIDTH = 16,
    parameter int DIV   = 25,
    parameter int DEB   = 3
) (
    input  logic             clk50,
    input  logic             reset,
    input  logic             en,
    input  logic             q7,
    output logic             pl_n,
    output logic             cp,
    output logic [WIDTH-1:0] data,
    output logic             valid,
    output logic             changed
);

    localparam int TW = $clog2(DIV);
    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int SW = (DEB > 1) ? $clog2(DEB) : 1;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        LATCH,
        SHIFT,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [TW-1:0]    tickCnt_q, tickCnt_d;
    logic             ph_q, ph_d;
    logic [BW-1:0]    bitCnt_q, bitCnt_d;
    logic [WIDTH-1:0] shiftReg_q, shiftReg_d;
    logic [WIDTH-1:0] lastRaw_q, lastRaw_d;
    logic [SW-1:0]    stab_q, stab_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic             changed_q, changed_d;
    logic             plN_q, plN_d;
    logic             cp_q, cp_d;
    logic             q7Meta_q, q7Sync_q;
    logic             tick;
    logic             scanDone;
    logic [WIDTH-1:0] shiftIn;

    // Shifted word with the newest synchronized bit entering at the LSB.
    if (WIDTH == 1) begin : gNarrow
        assign shiftIn = q7Sync_q;
    end else begin : gWide
        assign shiftIn = {shiftReg_q[WIDTH-2:0], q7Sync_q};
    end

    assign tick = (tickCnt_q == TW'(DIV - 1));

    // Two-flop synchronizer for the chain's serial output, which is asynchronous to clk50.
    always_ff @(posedge clk50 or posedge reset) begin
        if (reset) begin
            q7Meta_q <= 1'b0;
            q7Sync_q <= 1'b0;
        end else begin
            q7Meta_q <= q7;
            q7Sync_q <= q7Meta_q;
        end
    end

    // Scan sequencing: tick counter, state, shift phase, bit count and shift register.
    always_comb begin
        state_d    = state_q;
        ph_d       = ph_q;
        bitCnt_d   = bitCnt_q;
        shiftReg_d = shiftReg_q;
        scanDone   = 1'b0;
        tickCnt_d  = (state_q == IDLE || tick) ? '0 : tickCnt_q + TW'(1);
        case (state_q)
            IDLE: begin
                if (en) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (tick) begin
                    state_d = LATCH;
                end
            end
            LATCH: begin
                if (tick) begin
                    state_d  = SHIFT;
                    ph_d     = 1'b0;
                    bitCnt_d = '0;
                end
            end
            SHIFT: begin
                if (tick) begin
                    if (!ph_q) begin
                        shiftReg_d = shiftIn;
                        ph_d       = 1'b1;
                    end else begin
                        ph_d     = 1'b0;
                        bitCnt_d = bitCnt_q + BW'(1);
                        if (bitCnt_q == BW'(WIDTH - 1)) begin
                            state_d = DONE;
                        end
                    end
                end
            end
            DONE: begin
                if (tick) begin
                    scanDone = 1'b1;
                    state_d  = en ? LOAD : IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Debounce of the completed scan word and the chain control outputs, decoded from next state.
    always_comb begin
        stab_d    = stab_q;
        lastRaw_d = lastRaw_q;
        data_d    = data_q;
        changed_d = 1'b0;
        valid_d   = scanDone;
        if (scanDone) begin
            if (shiftReg_q == lastRaw_q) begin
                stab_d = (stab_q == SW'(DEB - 1)) ? stab_q : stab_q + SW'(1);
            end else begin
                stab_d    = '0;
                lastRaw_d = shiftReg_q;
            end
            if (stab_d == SW'(DEB - 1) && shiftReg_q != data_q) begin
                data_d    = shiftReg_q;
                changed_d = 1'b1;
            end
        end
        plN_d = (state_d != LOAD);
        cp_d  = (state_d == SHIFT) && ph_d;
    end

    // State and output registers; reset discards any partial scan.
    always_ff @(posedge clk50 or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            tickCnt_q  <= '0;
            ph_q       <= 1'b0;
            bitCnt_q   <= '0;
            shiftReg_q <= '0;
            lastRaw_q  <= '0;
            stab_q     <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            changed_q  <= 1'b0;
            plN_q      <= 1'b1;
            cp_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            tickCnt_q  <= tickCnt_d;
            ph_q       <= ph_d;
            bitCnt_q   <= bitCnt_d;
            shiftReg_q <= shiftReg_d;
            lastRaw_q  <= lastRaw_d;
            stab_q     <= stab_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            changed_q  <= changed_d;
            plN_q      <= plN_d;
            cp_q       <= cp_d;
        end
    end

    assign pl_n    = plN_q;
    assign cp      = cp_q;
    assign data    = data_q;
    assign valid   = valid_q;
    assign changed = changed_q;

endmodule

// File: tb/tb_sr_scan.sv
// tb_sr_scan: directed bench for sr_scan with a behavioural 74HC165 chain.
module tb_sr_scan;

    localparam int WIDTH = 16;
    localparam int DIV   = 4;
    localparam int DEB   = 3;
    localparam int SCAN  = (3 + 2 * WIDTH) * DIV;

    logic             clk50 = 1'b0;
    logic             reset = 1'b1;
    logic             en = 1'b0;
    logic             q7;
    logic             pl_n;
    logic             cp;
    logic [WIDTH-1:0] data;
    logic             valid;
    logic             changed;

    logic [WIDTH-1:0] par = '0;
    logic [WIDTH-1:0] chainReg = '0;
    logic             cpPrev = 1'b0;

    int checks = 0;
    int failures = 0;

    sr_scan #(.WIDTH(WIDTH), .DIV(DIV), .DEB(DEB)) dut (
        .clk50  (clk50),
        .reset  (reset),
        .en     (en),
        .q7     (q7),
        .pl_n   (pl_n),
        .cp     (cp),
        .data   (data),
        .valid  (valid),
        .changed(changed)
    );

    always #5 clk50 = ~clk50;

    // Chain model: follows the parallel inputs while pl_n is low, shifts on each cp rise.
    always @(posedge clk50) begin
        cpPrev <= cp;
        if (!pl_n) begin
            chainReg <= par;
        end else if (cp && !cpPrev) begin
            chainReg <= {chainReg[WIDTH-2:0], 1'b0};
        end
    end

    assign q7 = chainReg[WIDTH-1];

    task automatic waitValid(input int maxCyc, output bit ok, output int cyc);
        ok  = 1'b0;
        cyc = 0;
        while (!ok && cyc < maxCyc) begin
            @(negedge clk50);
            cyc++;
            if (valid === 1'b1) ok = 1'b1;
        end
    endtask

    task automatic waitRises(input int n, input int maxCyc, output bit ok);
        int   cnt = 0;
        int   cyc = 0;
        logic prev;
        prev = cp;
        while (cnt < n && cyc < maxCyc) begin
            @(negedge clk50);
            cyc++;
            if (cp === 1'b1 && prev !== 1'b1) cnt++;
            prev = cp;
        end
        ok = (cnt == n);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        en    = 1'b0;
        par   = 16'hA5C3;
        repeat (3) @(negedge clk50);
        checks++;
        if (pl_n !== 1'b1) begin failures++; $display("[TB] FAIL reset_pl_n got=%b exp=1", pl_n); end
        checks++;
        if (cp !== 1'b0) begin failures++; $display("[TB] FAIL reset_cp got=%b exp=0", cp); end
        checks++;
        if (data !== 16'h0000) begin failures++; $display("[TB] FAIL reset_data got=%h exp=0000", data); end
        checks++;
        if (valid !== 1'b0 || changed !== 1'b0) begin
            failures++; $display("[TB] FAIL reset_pulses got valid=%b changed=%b exp=0/0", valid, changed);
        end
        reset = 1'b0;
        en    = 1'b1;
        #1;
        checks++;
        if (pl_n !== 1'b1) begin failures++; $display("[TB] FAIL release_pl_n_hold got=%b exp=1", pl_n); end
        @(negedge clk50);
        checks++;
        if (pl_n !== 1'b0) begin failures++; $display("[TB] FAIL release_pl_n_fall got=%b exp=0", pl_n); end
    endtask

    task automatic test_back_to_back();
        bit               ok;
        int               cyc;
        logic [WIDTH-1:0] expData;
        logic             expChg;
        for (int i = 0; i < 5; i++) begin
            waitValid(SCAN + 20, ok, cyc);
            checks++;
            if (!ok) begin failures++; $display("[TB] FAIL static_valid_timeout scan=%0d got=none exp=valid", i); end
            if (i > 0) begin
                checks++;
                if (cyc != SCAN) begin failures++; $display("[TB] FAIL static_period got=%0d exp=%0d", cyc, SCAN); end
            end
            expData = (i >= 2) ? 16'hA5C3 : 16'h0000;
            expChg  = (i == 2);
            checks++;
            if (data !== expData) begin failures++; $display("[TB] FAIL static_data scan=%0d got=%h exp=%h", i, data, expData); end
            checks++;
            if (changed !== expChg) begin failures++; $display("[TB] FAIL static_changed scan=%0d got=%b exp=%b", i, changed, expChg); end
        end
    endtask

    task automatic test_waveform();
        bit   ok;
        int   cyc;
        int   plLow = 0;
        int   gap = 0;
        int   rises = 0;
        int   highRun = 0;
        int   lowRun = 0;
        int   badHigh = 0;
        int   badLow = 0;
        int   guard = 0;
        logic prevCp;
        waitValid(SCAN + 20, ok, cyc);
        checks++;
        if (!ok) begin failures++; $display("[TB] FAIL wave_valid_timeout got=none exp=valid"); end
        while (pl_n === 1'b0 && guard < 50) begin
            plLow++;
            guard++;
            @(negedge clk50);
        end
        checks++;
        if (plLow != DIV) begin failures++; $display("[TB] FAIL wave_pl_low got=%0d exp=%0d", plLow, DIV); end
        while (cp === 1'b0 && guard < 100) begin
            gap++;
            guard++;
            @(negedge clk50);
        end
        checks++;
        if (gap != 2 * DIV) begin failures++; $display("[TB] FAIL wave_first_rise got=%0d exp=%0d", gap, 2 * DIV); end
        rises   = 1;
        highRun = 1;
        prevCp  = 1'b1;
        guard   = 0;
        while (valid !== 1'b1 && guard < 2 * SCAN) begin
            @(negedge clk50);
            guard++;
            if (cp === 1'b1 && prevCp !== 1'b1) begin
                rises++;
                if (lowRun != DIV) badLow++;
                highRun = 1;
            end else if (cp === 1'b1) begin
                highRun++;
            end else if (prevCp === 1'b1) begin
                if (highRun != DIV) badHigh++;
                lowRun = 1;
            end else begin
                lowRun++;
            end
            prevCp = cp;
        end
        checks++;
        if (rises != WIDTH) begin failures++; $display("[TB] FAIL wave_cp_rises got=%0d exp=%0d", rises, WIDTH); end
        checks++;
        if (badHigh != 0) begin failures++; $display("[TB] FAIL wave_cp_high got=%0d_bad exp=0_bad", badHigh); end
        checks++;
        if (badLow != 0) begin failures++; $display("[TB] FAIL wave_cp_low got=%0d_bad exp=0_bad", badLow); end
        checks++;
        if (data !== 16'hA5C3) begin failures++; $display("[TB] FAIL wave_data got=%h exp=a5c3", data); end
    endtask

    task automatic test_enable_mid_scan();
        bit ok;
        int cyc;
        int bad = 0;
        waitRises(5, SCAN, ok);
        checks++;
        if (!ok) begin failures++; $display("[TB] FAIL en_rise_timeout got=none exp=5_rises"); end
        en = 1'b0;
        waitValid(2 * SCAN, ok, cyc);
        checks++;
        if (!ok) begin failures++; $display("[TB] FAIL en_finish_valid got=none exp=valid"); end
        checks++;
        if (data !== 16'hA5C3) begin failures++; $display("[TB] FAIL en_finish_data got=%h exp=a5c3", data); end
        for (int i = 0; i < 2 * SCAN; i++) begin
            @(negedge clk50);
            if (pl_n !== 1'b1 || cp !== 1'b0 || valid !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin failures++; $display("[TB] FAIL en_idle got=%0d_bad_cycles exp=0", bad); end
        en = 1'b1;
        @(negedge clk50);
        checks++;
        if (pl_n !== 1'b0) begin failures++; $display("[TB] FAIL en_restart_load got=%b exp=0", pl_n); end
        waitValid(SCAN + 20, ok, cyc);
        checks++;
        if (!ok || cyc != SCAN) begin failures++; $display("[TB] FAIL en_restart_len got=%0d exp=%0d", cyc, SCAN); end
    endtask

    task automatic test_bounce();
        bit               ok;
        int               cyc;
        logic [WIDTH-1:0] seq [9];
        logic [WIDTH-1:0] expData;
        logic             expChg;
        seq = '{16'h0001, 16'h0000, 16'h0001, 16'h0000, 16'h0001, 16'h0000,
                16'h0001, 16'h0001, 16'h0001};
        reset = 1'b1;
        par   = seq[0];
        repeat (2) @(negedge clk50);
        checks++;
        if (data !== 16'h0000) begin failures++; $display("[TB] FAIL bounce_reset_data got=%h exp=0000", data); end
        reset = 1'b0;
        for (int i = 0; i < 9; i++) begin
            waitValid(SCAN + 20, ok, cyc);
            checks++;
            if (!ok) begin failures++; $display("[TB] FAIL bounce_valid_timeout scan=%0d got=none exp=valid", i); end
            if (i < 8) par = seq[i+1];
            expData = (i == 8) ? 16'h0001 : 16'h0000;
            expChg  = (i == 8);
            checks++;
            if (data !== expData) begin failures++; $display("[TB] FAIL bounce_data scan=%0d got=%h exp=%h", i, data, expData); end
            checks++;
            if (changed !== expChg) begin failures++; $display("[TB] FAIL bounce_changed scan=%0d got=%b exp=%b", i, changed, expChg); end
        end
    endtask

    task automatic test_reset_mid_shift();
        bit               ok;
        int               cyc;
        logic [WIDTH-1:0] expData;
        par = 16'hFFFF;
        waitRises(9, SCAN, ok);
        checks++;
        if (!ok) begin failures++; $display("[TB] FAIL midrst_rise_timeout got=none exp=9_rises"); end
        reset = 1'b1;
        #1;
        checks++;
        if (data !== 16'h0000) begin failures++; $display("[TB] FAIL midrst_data got=%h exp=0000", data); end
        checks++;
        if (pl_n !== 1'b1 || cp !== 1'b0) begin
            failures++; $display("[TB] FAIL midrst_ctrl got pl_n=%b cp=%b exp=1/0", pl_n, cp);
        end
        checks++;
        if (valid !== 1'b0 || changed !== 1'b0) begin
            failures++; $display("[TB] FAIL midrst_pulses got valid=%b changed=%b exp=0/0", valid, changed);
        end
        repeat (3) @(negedge clk50);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            waitValid(SCAN + 20, ok, cyc);
            checks++;
            if (!ok) begin failures++; $display("[TB] FAIL midrst_valid_timeout scan=%0d got=none exp=valid", i); end
            expData = (i == 2) ? 16'hFFFF : 16'h0000;
            checks++;
            if (data !== expData) begin failures++; $display("[TB] FAIL midrst_data_scan scan=%0d got=%h exp=%h", i, data, expData); end
            checks++;
            if (changed !== (i == 2)) begin failures++; $display("[TB] FAIL midrst_changed scan=%0d got=%b exp=%b", i, changed, (i == 2)); end
        end
    endtask

    // Runs every scenario in order, then reports the totals.
    initial begin
        test_reset();
        test_back_to_back();
        test_waveform();
        test_enable_mid_scan();
        test_bounce();
        test_reset_mid_shift();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
